// File: rtl/led_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_encoder
// Brief    : Time-multiplexed multi-digit seven-segment driver with
//            frame-aligned double buffering. Define LED_SCAN_BLANK_EN for
//            leading-zero blanking.
// Revision : 1.0
// ============================================================================
module led_scan_encoder #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  in_valid,
    output logic [6:0]            out,
    output logic                  dp,
    output logic [DIGITS-1:0]     led,
    output logic                  pending,
    output logic                  frame
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = 5 * DIGITS;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     disp_q, disp_d;
    logic [DW-1:0]     shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              frame_q, frame_d;
    logic [6:0]        out_q, out_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] led_q, led_d;

    logic              w_tick;
    logic              w_wrap;
    logic              w_commit;
    logic [3:0]        w_nib;
    logic              w_dpbit;
`ifdef LED_SCAN_BLANK_EN
    logic              w_blank;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        w_tick = (cnt_q == CNT_MAX);
        cnt_d  = w_tick ? '0 : cnt_q + CW'(1);

        idx_d = idx_q;
        if (w_tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        w_wrap   = w_tick && (idx_d == '0);
        w_commit = w_wrap && pending_q;

        // Commit uses the shadow as it stood before this edge's strobe.
        disp_d    = w_commit ? shadow_q : disp_q;
        shadow_d  = in_valid ? {dp_in, in} : shadow_q;
        pending_d = in_valid | (pending_q & ~w_commit);
        frame_d   = w_wrap;

        w_nib   = 4'h0;
        w_dpbit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                w_nib   = disp_d[4*k +: 4];
                w_dpbit = disp_d[4*DIGITS + k];
            end
        end

`ifdef LED_SCAN_BLANK_EN
        // Blank when every nibble from this digit upward is zero.
        w_blank = (idx_d != '0) &&
                  ((disp_d[4*DIGITS-1:0] >> {idx_d, 2'b00}) == '0);
`endif

        led_d = led_q;
        out_d = out_q;
        dp_d  = dp_q;
        if (w_tick) begin
            led_d = DIGITS'(1) << idx_d;
            out_d = seg7(w_nib);
`ifdef LED_SCAN_BLANK_EN
            if (w_blank) begin
                out_d = 7'b1111111;
            end
`endif
            dp_d  = ~w_dpbit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            frame_q   <= 1'b0;
            out_q     <= 7'b1000000;
            dp_q      <= 1'b1;
            led_q     <= DIGITS'(1);
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            out_q     <= out_d;
            dp_q      <= dp_d;
            led_q     <= led_d;
        end
    end

    assign out     = out_q;
    assign dp      = dp_q;
    assign led     = led_q;
    assign pending = pending_q;
    assign frame   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_encoder
// Brief    : Directed bench for led_scan_encoder (DIGITS=4, SCAN_DIV=4) with an
//            edge-count reference model and literal spot checks.
// Revision : 1.0
// ============================================================================
module tb_led_scan_encoder;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic [15:0] din  = '0;
    logic [3:0]  dpin = '0;
    logic        vld  = 1'b0;
    logic [6:0]  out;
    logic        dp;
    logic [3:0]  led;
    logic        pending;
    logic        frame;

    int total  = 0;
    int passes = 0;

    led_scan_encoder #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (din),
        .dp_in    (dpin),
        .in_valid (vld),
        .out      (out),
        .dp       (dp),
        .led      (led),
        .pending  (pending),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] BLANK = 7'b1111111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Model state: edges since reset release, committed and pending words.
    int          e = 0;
    logic [19:0] m_disp   = '0;
    logic [19:0] m_shadow = '0;
    logic        m_pend   = 1'b0;
    logic [6:0]  m_out    = 7'b1000000;
    logic        m_dp     = 1'b1;
    logic [3:0]  m_led    = 4'b0001;
    logic        m_frame  = 1'b0;

    function automatic logic [6:0] model_seg(input logic [19:0] v, input int d);
        logic [15:0] nibs;
        nibs = v[15:0];
`ifdef LED_SCAN_BLANK_EN
        if (d > 0 && (nibs >> (4 * d)) == 16'h0) return BLANK;
`endif
        return seg_tab[(nibs >> (4 * d)) & 16'hF];
    endfunction

    always @(posedge clk) begin
        int d;
        if (!rst) begin
            e = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
            m_out = 7'b1000000; m_dp = 1'b1; m_led = 4'b0001; m_frame = 1'b0;
        end else begin
            e++;
            m_frame = (e % FRAME == 0);
            if (m_frame && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (vld) begin
                m_shadow = {dpin, din};
                m_pend   = 1'b1;
            end
            if (e % SCAN_DIV == 0) begin
                d     = (e / SCAN_DIV) % DIGITS;
                m_led = 4'(1 << d);
                m_out = model_seg(m_disp, d);
                m_dp  = ~m_disp[16 + d];
            end
        end
        #1;
        chk("model_out", 32'(out), 32'(m_out));
        chk("model_dp", 32'(dp), 32'(m_dp));
        chk("model_led", 32'(led), 32'(m_led));
        chk("model_pending", 32'(pending), 32'(m_pend));
        chk("model_frame", 32'(frame), 32'(m_frame));
    end

    // Advance to the falling edge where e mod FRAME equals m.
    task automatic wait_mod(input int m);
        int n = 0;
        while (e % FRAME != m && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (e % FRAME != m) chk("wait_mod_timeout", 32'(e % FRAME), 32'(m));
    endtask

    task automatic strobe(input logic [15:0] v, input logic [3:0] p);
        din  = v;
        dpin = p;
        vld  = 1'b1;
        @(negedge clk);
        vld  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_out", 32'(out), 32'h40);
        chk("rst_led", 32'(led), 32'h1);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_pending", 32'(pending), 32'h0);

        // Idle scan: first tick selects digit 1, frame after 16 clocks.
        wait_mod(4);
        chk("idle_led_d1", 32'(led), 32'b0010);
        wait_mod(1);
        wait_mod(0);
        chk("idle_frame", 32'(frame), 32'h1);
        chk("idle_led_d0", 32'(led), 32'b0001);

        // Single strobe mid-frame.
        wait_mod(5);
        strobe(16'h1A3F, 4'b0000);
        chk("p1_pending", 32'(pending), 32'h1);
        chk("p1_hold_out", 32'(out), 32'h40);
        wait_mod(0);
        chk("p1_d0", 32'(out), 32'b0001110);
        chk("p1_pending_clr", 32'(pending), 32'h0);
        wait_mod(4);
        chk("p1_d1", 32'(out), 32'b0110000);
        wait_mod(8);
        chk("p1_d2", 32'(out), 32'b0001000);
        wait_mod(12);
        chk("p1_d3", 32'(out), 32'b1111001);

        // Last strobe wins.
        wait_mod(3);
        strobe(16'h1111, 4'b0000);
        wait_mod(8);
        strobe(16'h2222, 4'b0000);
        wait_mod(0);
        chk("p2_d0", 32'(out), 32'b0100100);
        wait_mod(4);
        chk("p2_d1", 32'(out), 32'b0100100);

        // Strobe on the wrap-tick cycle with an older value pending.
        wait_mod(5);
        strobe(16'h1234, 4'b0000);
        wait_mod(15);
        strobe(16'h5555, 4'b0000);
        chk("p3_d0_1234", 32'(out), 32'b0011001);
        chk("p3_pending_kept", 32'(pending), 32'h1);
        wait_mod(4);
        chk("p3_d1_1234", 32'(out), 32'b0110000);
        wait_mod(0);
        chk("p3_d0_5555", 32'(out), 32'b0010010);
        chk("p3_pending_clr", 32'(pending), 32'h0);

        // Leading zeros and decimal point.
        wait_mod(5);
        strobe(16'h0007, 4'b0100);
        wait_mod(0);
        chk("p4_d0", 32'(out), 32'b1111000);
        chk("p4_d0_dp", 32'(dp), 32'h1);
        wait_mod(4);
`ifdef LED_SCAN_BLANK_EN
        chk("p4_d1", 32'(out), 32'(BLANK));
`else
        chk("p4_d1", 32'(out), 32'b1000000);
`endif
        wait_mod(8);
        chk("p4_d2_dp", 32'(dp), 32'h0);
`ifdef LED_SCAN_BLANK_EN
        chk("p4_d2", 32'(out), 32'(BLANK));
`else
        chk("p4_d2", 32'(out), 32'b1000000);
`endif
        wait_mod(12);
        chk("p4_d3_dp", 32'(dp), 32'h1);

        // Remaining glyphs.
        wait_mod(5);
        strobe(16'h6789, 4'b1010);
        wait_mod(0);
        chk("p5_d0", 32'(out), 32'b0010000);
        wait_mod(5);
        strobe(16'hCDEB, 4'b0001);
        wait_mod(0);
        chk("p5_d0_b", 32'(out), 32'b0000011);
        wait_mod(14);

        // Reset mid-frame with a value pending.
        wait_mod(5);
        strobe(16'hABCD, 4'b1111);
        wait_mod(9);
        chk("p6_pre_led", 32'(led), 32'b0100);
        rst = 1'b0;
        #1;
        chk("p6_rst_out", 32'(out), 32'h40);
        chk("p6_rst_led", 32'(led), 32'h1);
        chk("p6_rst_dp", 32'(dp), 32'h1);
        chk("p6_rst_pending", 32'(pending), 32'h0);
        chk("p6_rst_frame", 32'(frame), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_mod(1);
        wait_mod(0);
        chk("p6_after_d0", 32'(out), 32'b1000000);
        wait_mod(4);
`ifdef LED_SCAN_BLANK_EN
        chk("p6_after_d1", 32'(out), 32'(BLANK));
`else
        chk("p6_after_d1", 32'(out), 32'b1000000);
`endif
        wait_mod(12);
        chk("p6_after_dp", 32'(dp), 32'h1);
        wait_mod(0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
